// File: rtl/alu_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_pkg
// Shared operand-source encoding for the execute-stage operand unit.
// Both the A and B selectors are decoded into one src_e kind so the
// forwarding matcher and the operand mux only deal with one encoding.
//   a_sel : 0 GPR rs, 1 HI, 2 LO, 3 zero
//   b_sel : 0 GPR rt, 1 HI, 2 LO, 3 sign_imm, 4 pc_plus_eight, others zero
// ---------------------------------------------------------------------------
package alu_operand_stage_pkg;

  typedef enum logic [2:0] {
    SRC_GPR  = 3'd0,
    SRC_HI   = 3'd1,
    SRC_LO   = 3'd2,
    SRC_IMM  = 3'd3,
    SRC_PC8  = 3'd4,
    SRC_ZERO = 3'd7
  } src_e;

  // Bit positions inside each stage's {hi_we, lo_we} pair.
  localparam int unsigned HILO_WE_LO = 0;
  localparam int unsigned HILO_WE_HI = 1;

  function automatic src_e decode_a_sel(input logic [1:0] sel);
    case (sel)
      2'd0:    return SRC_GPR;
      2'd1:    return SRC_HI;
      2'd2:    return SRC_LO;
      default: return SRC_ZERO;
    endcase
  endfunction

  function automatic src_e decode_b_sel(input logic [2:0] sel);
    case (sel)
      3'd0:    return SRC_GPR;
      3'd1:    return SRC_HI;
      3'd2:    return SRC_LO;
      3'd3:    return SRC_IMM;
      3'd4:    return SRC_PC8;
      default: return SRC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_fwd_select
// Priority forwarding matcher for one operand. Scans NUM_FWD younger stages
// and reports the result of the youngest (lowest index) stage that writes
// the requested source.
//   kind          : decoded operand source (only GPR/HI/LO can match)
//   addr          : GPR address for SRC_GPR; address 0 never matches
//   fwd_*         : forwarding bundle, stage i in slice i
//   data          : winning stage's value (GPR result, HI half or LO half)
//   hit           : some stage matched
//   not_ready     : the winning stage's result is not yet available
// ---------------------------------------------------------------------------
module alu_operand_stage_fwd_select
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_FWD        = 2
) (
  input  src_e                            kind,
  input  logic [REG_ADDR_WIDTH-1:0]       addr,
  input  logic [NUM_FWD-1:0]              fwd_valid,
  input  logic [NUM_FWD-1:0]              fwd_reg_write,
  input  logic [2*NUM_FWD-1:0]            fwd_hilo_write,
  input  logic [NUM_FWD-1:0]              fwd_ready,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_reg,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]   fwd_data,
  input  logic [2*NUM_FWD*DATA_WIDTH-1:0] fwd_hilo_data,
  output logic [DATA_WIDTH-1:0]           data,
  output logic                            hit,
  output logic                            not_ready
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    data      = '0;
    hit       = 1'b0;
    not_ready = 1'b0;
    // Walk from oldest to youngest so a younger match overwrites an older
    // one: lowest index ends up with highest priority.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      case (kind)
        SRC_GPR: begin
          if (fwd_valid[i] && fwd_reg_write[i] &&
              fwd_reg[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr &&
              addr != '0) begin
            hit       = 1'b1;
            data      = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
            not_ready = !fwd_ready[i];
          end
        end
        SRC_HI: begin
          if (fwd_valid[i] && fwd_hilo_write[2*i + HILO_WE_HI]) begin
            hit       = 1'b1;
            data      = fwd_hilo_data[(2*i + 1)*DATA_WIDTH +: DATA_WIDTH];
            not_ready = !fwd_ready[i];
          end
        end
        SRC_LO: begin
          if (fwd_valid[i] && fwd_hilo_write[2*i + HILO_WE_LO]) begin
            hit       = 1'b1;
            data      = fwd_hilo_data[(2*i)*DATA_WIDTH +: DATA_WIDTH];
            not_ready = !fwd_ready[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Execute-stage operand unit: selects A/B sources, resolves GPR and HI/LO
// forwarding from NUM_FWD younger stages, detects load-use hazards and
// registers src_a/src_b into a one-deep valid/ready slot feeding the ALU.
//   clk, reset       : clock, synchronous active-high reset
//   flush            : kill the output slot and the incoming operand
//   in_valid/in_ready: upstream handshake
//   a_sel, b_sel     : operand source selects
//   rs_*/rt_*        : register addresses and register-file read data
//   hilo_data        : architectural {HI,LO}
//   sign_imm, pc_plus_eight : immediate and link address
//   fwd_*            : forwarding bundle, index 0 = youngest
//   out_valid/out_ready : ALU handshake; src_a/src_b registered operands
//   hazard           : incoming operand waits on an unready source
//   stall_count      : saturating count of hazard cycles
// ---------------------------------------------------------------------------
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_FWD        = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      a_sel,
  input  logic [2:0]                      b_sel,
  input  logic [REG_ADDR_WIDTH-1:0]       rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0]       rt_addr,
  input  logic [DATA_WIDTH-1:0]           rs_data,
  input  logic [DATA_WIDTH-1:0]           rt_data,
  input  logic [2*DATA_WIDTH-1:0]         hilo_data,
  input  logic [DATA_WIDTH-1:0]           sign_imm,
  input  logic [DATA_WIDTH-1:0]           pc_plus_eight,
  input  logic [NUM_FWD-1:0]              fwd_valid,
  input  logic [NUM_FWD-1:0]              fwd_reg_write,
  input  logic [2*NUM_FWD-1:0]            fwd_hilo_write,
  input  logic [NUM_FWD-1:0]              fwd_ready,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_reg,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]   fwd_data,
  input  logic [2*NUM_FWD*DATA_WIDTH-1:0] fwd_hilo_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           src_a,
  output logic [DATA_WIDTH-1:0]           src_b,
  output logic                            hazard,
  output logic [CNT_WIDTH-1:0]            stall_count
);

  src_e                  a_kind, b_kind;
  logic [DATA_WIDTH-1:0] a_fwd, b_fwd;
  logic                  a_hit, b_hit;
  logic                  a_not_ready, b_not_ready;
  logic [DATA_WIDTH-1:0] a_base, b_base;
  logic [DATA_WIDTH-1:0] a_next, b_next;
  logic                  slot_free;

  assign a_kind = decode_a_sel(a_sel);
  assign b_kind = decode_b_sel(b_sel);

  alu_operand_stage_fwd_select #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .NUM_FWD       (NUM_FWD)
  ) u_fwd_a (
    .kind          (a_kind),
    .addr          (rs_addr),
    .fwd_valid     (fwd_valid),
    .fwd_reg_write (fwd_reg_write),
    .fwd_hilo_write(fwd_hilo_write),
    .fwd_ready     (fwd_ready),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data),
    .fwd_hilo_data (fwd_hilo_data),
    .data          (a_fwd),
    .hit           (a_hit),
    .not_ready     (a_not_ready)
  );

  alu_operand_stage_fwd_select #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .NUM_FWD       (NUM_FWD)
  ) u_fwd_b (
    .kind          (b_kind),
    .addr          (rt_addr),
    .fwd_valid     (fwd_valid),
    .fwd_reg_write (fwd_reg_write),
    .fwd_hilo_write(fwd_hilo_write),
    .fwd_ready     (fwd_ready),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data),
    .fwd_hilo_data (fwd_hilo_data),
    .data          (b_fwd),
    .hit           (b_hit),
    .not_ready     (b_not_ready)
  );

  // Architectural (non-forwarded) value for each source kind. Register-file
  // data passes through untouched, even for r0.
  always_comb begin
    a_base = '0;
    case (a_kind)
      SRC_GPR: a_base = rs_data;
      SRC_HI:  a_base = hilo_data[2*DATA_WIDTH-1:DATA_WIDTH];
      SRC_LO:  a_base = hilo_data[DATA_WIDTH-1:0];
      default: a_base = '0;
    endcase
  end

  always_comb begin
    b_base = '0;
    case (b_kind)
      SRC_GPR: b_base = rt_data;
      SRC_HI:  b_base = hilo_data[2*DATA_WIDTH-1:DATA_WIDTH];
      SRC_LO:  b_base = hilo_data[DATA_WIDTH-1:0];
      SRC_IMM: b_base = sign_imm;
      SRC_PC8: b_base = pc_plus_eight;
      default: b_base = '0;
    endcase
  end

  // Matcher only ever hits for GPR/HI/LO kinds, so immediates, pc+8 and
  // zero can neither forward nor raise a hazard.
  assign a_next = a_hit ? a_fwd : a_base;
  assign b_next = b_hit ? b_fwd : b_base;

  assign hazard    = in_valid && (a_not_ready || b_not_ready);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      src_a       <= '0;
      src_b       <= '0;
      stall_count <= '0;
    end else begin
      // Counts every hazard cycle, including flushed ones; saturates.
      if (hazard && stall_count != '1)
        stall_count <= stall_count + CNT_WIDTH'(1);

      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        src_a     <= a_next;
        src_b     <= b_next;
      end else if (slot_free) begin
        // Bubble (hazard) or drained slot with nothing new: operands hold.
        out_valid <= 1'b0;
      end
      // Otherwise the slot is stalled by the ALU and everything holds.
    end
  end

endmodule
